// File: rtl/slave_fifo_rd_ctrl.sv
// FX3 Slave-FIFO read master: pulls words from an FX3 OUT socket into a
// first-word-fall-through buffer and presents them as a valid/ready stream.
module slave_fifo_rd_ctrl #(
   parameter int         DATA_W     = 32,
   parameter int         RD_LATENCY = 2,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [1:0] FADDR      = 2'd3,
   parameter int         FLUSH_CYC  = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              flagc,
   input  logic              flagd,
   input  logic [DATA_W-1:0] fdata_in,
   output logic [1:0]        faddr,
   output logic              slcs,
   output logic              sloe,
   output logic              slrd,
   output logic              slwr,
   output logic              pktend,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [31:0]       words_rx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int UW = CW + $clog2(RD_LATENCY + 2);
   localparam int FW = $clog2(FLUSH_CYC + 1);

   typedef enum logic [1:0] {IDLE, BURST, SINGLE, FLUSH} state_t;

   state_t            state, state_nx;
   logic              flagc_d, flagd_d;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [FW-1:0]     flush_cnt, flush_cnt_nx;
   logic [UW-1:0]     used;
   logic              push, pop, credit, slrd_nx;

   assign faddr   = FADDR;
   assign slwr    = 1'b1;
   assign pktend  = 1'b1;
   assign push    = rd_pipe[RD_LATENCY-1];
   assign m_valid = (count != '0);
   assign pop     = m_valid & m_ready;
   assign m_data  = mem[rd_ptr];

   // Words buffered plus every read already committed on the bus,
   // including the strobe that is low right now.
   always_comb begin
      used = UW'(count);
      for (int i = 0; i < RD_LATENCY; i++)
         used = used + UW'(rd_pipe[i]);
      used = used + UW'(!slrd);
   end

   assign credit = (used < UW'(FIFO_DEPTH));

   always_comb begin
      state_nx     = state;
      slrd_nx      = 1'b1;
      flush_cnt_nx = flush_cnt;
      unique case (state)
         IDLE: begin
            if (enable && flagc_d)
               state_nx = flagd_d ? BURST : SINGLE;
         end
         BURST: begin
            if (!flagd_d || !flagc_d) begin
               state_nx     = FLUSH;
               flush_cnt_nx = '0;
            end else if (credit) begin
               slrd_nx = 1'b0;
            end
         end
         SINGLE: begin
            if (credit) begin
               slrd_nx      = 1'b0;
               state_nx     = FLUSH;
               flush_cnt_nx = '0;
            end
         end
         FLUSH: begin
            if (flush_cnt == FW'(FLUSH_CYC - 1))
               state_nx = IDLE;
            else
               flush_cnt_nx = flush_cnt + FW'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         flush_cnt <= '0;
         flagc_d   <= 1'b0;
         flagd_d   <= 1'b0;
         slcs      <= 1'b1;
         sloe      <= 1'b1;
         slrd      <= 1'b1;
         rd_pipe   <= '0;
      end else begin
         state     <= state_nx;
         flush_cnt <= flush_cnt_nx;
         flagc_d   <= flagc;
         flagd_d   <= flagd;
         slcs      <= (state_nx == IDLE);
         sloe      <= (state_nx == IDLE);
         slrd      <= slrd_nx;
         rd_pipe[0] <= ~slrd;
         for (int i = 1; i < RD_LATENCY; i++)
            rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= fdata_in;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         words_rx <= '0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + AW'(1);
            words_rx <= words_rx + 32'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_slave_fifo_rd_ctrl.sv
// Bench for slave_fifo_rd_ctrl: FX3 socket model feeds a scoreboard queue,
// a monitor checks stream order, occupancy and strobe counts.
module tb_slave_fifo_rd_ctrl;

   localparam int DW    = 32;
   localparam int RDL   = 2;
   localparam int DEPTH = 16;
   localparam int WM    = 6;

   logic          clk      = 1'b0;
   logic          reset    = 1'b1;
   logic          enable   = 1'b0;
   logic          flagc    = 1'b0;
   logic          flagd    = 1'b0;
   logic [DW-1:0] fdata_in = '0;
   logic          m_ready  = 1'b1;
   logic [1:0]    faddr;
   logic          slcs, sloe, slrd, slwr, pktend;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic [31:0]   words_rx;

   logic [31:0] sock [$];
   logic [31:0] exp_q [$];
   logic [31:0] fx_pipe [RDL] = '{default: 32'hBAD0_0000};
   int          total  = 0;
   int          bad    = 0;
   int          issued = 0;
   int          popped = 0;
   int          seq    = 0;
   logic [31:0] rx_exp = '0;
   logic [31:0] mon_w;
   logic        rnd_mode = 1'b0;

   slave_fifo_rd_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .flagc    (flagc),
      .flagd    (flagd),
      .fdata_in (fdata_in),
      .faddr    (faddr),
      .slcs     (slcs),
      .sloe     (sloe),
      .slrd     (slrd),
      .slwr     (slwr),
      .pktend   (pktend),
      .m_data   (m_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .words_rx (words_rx)
   );

   always #5 clk = ~clk;

   // FX3 socket: a strobe seen low is consumed at the coming edge and its
   // word is on the bus for the edge RDL cycles after that.
   always @(negedge clk) begin
      fdata_in = fx_pipe[RDL-1];
      for (int i = RDL - 1; i > 0; i--)
         fx_pipe[i] = fx_pipe[i-1];
      fx_pipe[0] = 32'hBAD0_0000;
      if (!slrd && !slcs && sock.size() > 0) begin
         fx_pipe[0] = sock.pop_front();
         exp_q.push_back(fx_pipe[0]);
      end
      flagc = (sock.size() > 0);
      flagd = (sock.size() > WM);
   end

   always @(negedge clk) begin
      if (rnd_mode)
         m_ready = 1'($urandom_range(0, 1));
   end

   always @(posedge clk) begin
      if (reset) begin
         issued = 0;
         popped = 0;
      end else begin
         if (!slrd && !slcs)
            issued++;
         if (m_valid && m_ready) begin
            popped++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_word got=%h want=none", m_data);
            end else begin
               mon_w = exp_q.pop_front();
               if (m_data !== mon_w) begin
                  bad++;
                  $display("FAIL stream_order got=%h want=%h",
                           m_data, mon_w);
               end
            end
         end
         total++;
         if (issued - popped > DEPTH) begin
            bad++;
            $display("FAIL occupancy got=%0d want<=%0d",
                     issued - popped, DEPTH);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic load(input int n);
      for (int i = 0; i < n; i++) begin
         sock.push_back(32'(seq));
         seq++;
      end
      rx_exp = rx_exp + 32'(n);
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int n = 0;
      while (!(sock.size() == 0 && exp_q.size() == 0 &&
               sloe && slrd) && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= budget) begin
         bad++;
         $display("FAIL %s_timeout got=%0d want<%0d", nm, n, budget);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int base;
      int n;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      chk("rst_slrd", 32'(slrd), 32'd1);
      chk("rst_sloe", 32'(sloe), 32'd1);
      chk("rst_slcs", 32'(slcs), 32'd1);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_words", words_rx, 32'd0);
      chk("faddr", 32'(faddr), 32'd3);
      chk("slwr_pktend", 32'({slwr, pktend}), 32'd3);
      @(negedge clk);
      reset  = 1'b0;
      enable = 1'b1;

      // 40 words with the stream always ready
      seq = 0;
      load(40);
      wait_drain("burst40", 2000);
      chk("burst40_words", words_rx, 32'd40);
      chk("burst40_pops", 32'(popped), 32'd40);
      chk("burst40_idle", 32'(sloe & slcs), 32'd1);

      // stream stalled for a 100-word burst
      m_ready = 1'b0;
      seq = 1000;
      base = issued;
      load(100);
      repeat (80) @(negedge clk);
      chk("stall_reads", 32'(issued - base), 32'(DEPTH));
      chk("stall_valid", 32'(m_valid), 32'd1);
      m_ready = 1'b1;
      wait_drain("burst100", 4000);
      chk("burst100_words", words_rx, rx_exp);

      // small socket served by single reads
      seq = 2000;
      base = issued;
      load(3);
      wait_drain("single3", 500);
      chk("single3_reads", 32'(issued - base), 32'd3);
      chk("single3_words", words_rx, rx_exp);

      // reset pulse in the middle of a burst
      seq = 3000;
      load(50);
      repeat (14) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_slrd", 32'(slrd), 32'd1);
      chk("midrst_sloe", 32'(sloe), 32'd1);
      chk("midrst_valid", 32'(m_valid), 32'd0);
      chk("midrst_words", words_rx, 32'd0);
      exp_q.delete();
      for (int i = 0; i < RDL; i++)
         fx_pipe[i] = 32'hBAD0_0000;
      rx_exp = 32'(sock.size());
      @(negedge clk);
      reset = 1'b0;
      wait_drain("after_rst", 2000);
      chk("after_rst_words", words_rx, rx_exp);

      // ready toggling with the buffer one word short of full
      m_ready = 1'b0;
      seq = 4000;
      base = issued;
      load(60);
      n = 0;
      while (issued - base < DEPTH && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("fill_reads", 32'(issued - base), 32'(DEPTH));
      m_ready = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 60; i++) begin
         m_ready = ~m_ready;
         @(negedge clk);
      end
      m_ready = 1'b1;
      wait_drain("toggle", 3000);
      chk("toggle_words", words_rx, rx_exp);

      // word counter wrap
      force dut.words_rx = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.words_rx;
      rx_exp = 32'hFFFF_FFFE;
      seq = 5000;
      load(3);
      wait_drain("wrap", 500);
      chk("wrap_words", words_rx, 32'h0000_0001);

      // randomized socket sizes and backpressure
      for (int r = 0; r < 5; r++) begin
         seq = 6000 + r * 100;
         load(int'($urandom_range(1, 45)));
         rnd_mode = 1'b1;
         wait_drain("rand", 5000);
         rnd_mode = 1'b0;
         m_ready  = 1'b1;
         repeat (3) @(negedge clk);
         chk("rand_words", words_rx, rx_exp);
         chk("rand_empty", 32'(m_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
